// File: rtl/irq_controller_if.sv
// AXI-lite register window bundle used between the peripheral crossbar and irq_controller.
// 32-bit address and data; master drives requests, slave drives responses.
interface irq_controller_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/irq_controller.sv
// Interrupt controller: latches edge/level sources, masks them and presents one one-hot request
// to the core until eoi. Define IRQ_SYNC_EN to add a 2-flop synchronizer on every src line.
module irq_controller #(
  parameter int          N_SRC      = 32,
  parameter logic [31:0] RESET_EDGE = 32'h0
) (
  input  logic             clk,
  input  logic             resetn,
  irq_controller_if.slave  s_axi,
  input  logic [N_SRC-1:0] src,
  output logic [31:0]      irq,
  input  logic             eoi
);

  localparam logic [31:0] SRC_MASK = 32'((64'd1 << N_SRC) - 64'd1);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic {IDLE, SERVICE} state_e;

  state_e      state_q, state_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] enable_q, enable_d;
  logic [31:0] edge_q, edge_d;
  logic [31:0] srcPrev_q;
  logic [31:0] irq_q, irq_d;
  logic [4:0]  id_q, id_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  logic [31:0] srcExt, srcS, rise, swSet, w1c, eoiClr, cand, rdValue;
  logic [4:0]  lowIdx;
  logic        wrEn, rdEn;
  logic [11:0] wrOff, rdOff;
  logic        unusedBits;

  always_comb begin
    srcExt = '0;
    srcExt[N_SRC-1:0] = src;
  end

`ifdef IRQ_SYNC_EN
  logic [31:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= srcExt;
      sync2_q <= sync1_q;
    end
  end

  assign srcS = sync2_q;
`else
  assign srcS = srcExt;
`endif

  function automatic logic isMapped(input logic [11:0] off);
    return (off == 12'h000) || (off == 12'h004) || (off == 12'h008) ||
           (off == 12'h00C) || (off == 12'h010);
  endfunction

  // A write is taken only with both address and data present and no response outstanding.
  assign wrOff          = s_axi.awaddr[11:0];
  assign rdOff          = s_axi.araddr[11:0];
  assign wrEn           = s_axi.awvalid & s_axi.wvalid & ~bvalid_q;
  assign rdEn           = s_axi.arvalid & ~rvalid_q;
  assign s_axi.awready  = wrEn;
  assign s_axi.wready   = wrEn;
  assign s_axi.arready  = rdEn;
  assign s_axi.bvalid   = bvalid_q;
  assign s_axi.bresp    = bresp_q;
  assign s_axi.rvalid   = rvalid_q;
  assign s_axi.rdata    = rdata_q;
  assign s_axi.rresp    = rresp_q;
  assign irq            = irq_q;
  assign unusedBits     = ^{s_axi.wstrb, s_axi.awaddr[31:12], s_axi.araddr[31:12]};

  always_comb begin
    rdValue = '0;
    case (rdOff)
      12'h000: rdValue = pending_q;
      12'h004: rdValue = enable_q;
      12'h008: rdValue = edge_q;
      12'h00C: rdValue = {(state_q == SERVICE), 26'b0, id_q};
      default: rdValue = '0;
    endcase
  end

  always_comb begin
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (wrEn) begin
      bvalid_d = 1'b1;
      bresp_d  = isMapped(wrOff) ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axi.bready) begin
      bvalid_d = 1'b0;
    end
    if (rdEn) begin
      rvalid_d = 1'b1;
      rdata_d  = rdValue;
      rresp_d  = isMapped(rdOff) ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axi.rready) begin
      rvalid_d = 1'b0;
    end
  end

  // Sets (edge, SWSET) are OR-ed in after clears so a coincident set always wins.
  always_comb begin
    rise     = srcS & ~srcPrev_q;
    swSet    = (wrEn && wrOff == 12'h010) ? (s_axi.wdata & edge_q) : '0;
    w1c      = (wrEn && wrOff == 12'h000) ? (s_axi.wdata & edge_q) : '0;
    eoiClr   = (state_q == SERVICE && eoi) ? (32'd1 << id_q) : '0;
    pending_d = (edge_q & ((pending_q & ~(w1c | eoiClr)) | rise | swSet)) | (~edge_q & srcS);
    enable_d = (wrEn && wrOff == 12'h004) ? (s_axi.wdata & SRC_MASK) : enable_q;
    edge_d   = (wrEn && wrOff == 12'h008) ? (s_axi.wdata & SRC_MASK) : edge_q;
  end

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    id_d    = id_q;
    cand    = pending_q & enable_q;
    lowIdx  = '0;
    for (int i = 31; i >= 0; i--) begin
      if (cand[i]) lowIdx = 5'(i);
    end
    case (state_q)
      IDLE: begin
        if (cand != '0) begin
          state_d = SERVICE;
          id_d    = lowIdx;
          irq_d   = 32'd1 << lowIdx;
        end
      end
      SERVICE: begin
        if (eoi) begin
          state_d = IDLE;
          id_d    = '0;
          irq_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      pending_q <= '0;
      enable_q  <= '0;
      edge_q    <= RESET_EDGE & SRC_MASK;
      srcPrev_q <= '0;
      irq_q     <= '0;
      id_q      <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      edge_q    <= edge_d;
      srcPrev_q <= srcS;
      irq_q     <= irq_d;
      id_q      <= id_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Randomized bench for irq_controller against a cycle-level behavioural model of the register
// rules; directed sequences cover reset, edge/level servicing, set-beats-clear and AXI stalls.
module tb_irq_controller;

  localparam int          N     = 32;
  localparam logic [31:0] R_EDG = 32'h0000_0100;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic [N-1:0]  src;
  logic          eoi;
  logic [31:0]   irq;

  irq_controller_if bus();

  irq_controller #(.N_SRC(N), .RESET_EDGE(R_EDG)) dut (
    .clk(clk), .resetn(resetn), .s_axi(bus), .src(src), .irq(irq), .eoi(eoi)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  // Behavioural model state
  logic [31:0] mPend, mEn, mEdge, mPrev, mIrq, mS1, mS2;
  bit          mBusy;
  int          mId;
  bit          wrFire, rdFire;
  logic [31:0] wrAddr, wrData, rdAddr, rdExp;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic bit isMapped(input logic [31:0] a);
    return a == 32'h0 || a == 32'h4 || a == 32'h8 || a == 32'hC || a == 32'h10;
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    case (a)
      32'h0:   return mPend;
      32'h4:   return mEn;
      32'h8:   return mEdge;
      32'hC:   return mBusy ? (32'h8000_0000 | 32'(mId)) : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic modelReset();
    mPend = '0; mEn = '0; mEdge = R_EDG; mPrev = '0; mIrq = '0;
    mS1 = '0; mS2 = '0; mBusy = 0; mId = 0;
    wrFire = 0; rdFire = 0;
  endtask

  // One clock: advance the model with the inputs the DUT saw at this edge, then compare irq.
  task automatic tick();
    logic [31:0] s, set, clr, np;
    int low;
    @(posedge clk);
    if (!resetn) begin
      modelReset();
    end else begin
`ifdef IRQ_SYNC_EN
      s = mS2; mS2 = mS1; mS1 = src;
`else
      s = src;
`endif
      if (rdFire) begin
        rdExp = modelRead(rdAddr);
        rdFire = 0;
      end
      set = s & ~mPrev;
      clr = '0;
      if (wrFire && wrAddr == 32'h10) set |= wrData & mEdge;
      if (wrFire && wrAddr == 32'h0)  clr |= wrData & mEdge;
      if (mBusy && eoi) clr[mId] = 1'b1;
      for (int i = 0; i < 32; i++)
        np[i] = mEdge[i] ? ((mPend[i] & ~clr[i]) | set[i]) : s[i];
      if (!mBusy) begin
        low = -1;
        for (int i = 31; i >= 0; i--) if (mPend[i] & mEn[i]) low = i;
        if (low >= 0) begin
          mBusy = 1; mId = low; mIrq = 32'h1 << low;
        end
      end else if (eoi) begin
        mBusy = 0; mId = 0; mIrq = '0;
      end
      if (wrFire && wrAddr == 32'h4) mEn = wrData;
      if (wrFire && wrAddr == 32'h8) mEdge = wrData;
      wrFire = 0;
      mPend = np;
      mPrev = s;
    end
    #1;
    checkOutput("irq", irq, mIrq);
  endtask

  task automatic applyStimulus(input logic [N-1:0] s, input logic e);
    src = s;
    eoi = e;
    tick();
    eoi = 1'b0;
  endtask

  task automatic applyWrite(input logic [31:0] addr, input logic [31:0] data, input int stall);
    int n;
    eoi = 1'b0;
    bus.awaddr = addr; bus.wdata = data; bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    #1;
    checkOutput("awready", {31'b0, bus.awready & bus.wready}, 32'h1);
    wrFire = 1; wrAddr = addr; wrData = data;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    checkOutput("bvalid", {31'b0, bus.bvalid}, 32'h1);
    for (int i = 0; i < stall; i++) begin
      tick();
      checkOutput("bvalid_hold", {31'b0, bus.bvalid}, 32'h1);
    end
    bus.bready = 1'b1;
    n = 0;
    while (!bus.bvalid && n < 10) begin tick(); n++; end
    checkOutput("bresp", {30'b0, bus.bresp}, isMapped(addr) ? 32'h0 : 32'h2);
    tick();
    bus.bready = 1'b0;
    checkOutput("bvalid_drop", {31'b0, bus.bvalid}, 32'h0);
  endtask

  task automatic applyRead(input logic [31:0] addr, input int stall);
    int n;
    eoi = 1'b0;
    bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b0;
    #1;
    checkOutput("arready", {31'b0, bus.arready}, 32'h1);
    rdFire = 1; rdAddr = addr;
    tick();
    bus.arvalid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      tick();
      checkOutput("rvalid_hold", {31'b0, bus.rvalid}, 32'h1);
    end
    n = 0;
    while (!bus.rvalid && n < 10) begin tick(); n++; end
    checkOutput("rvalid", {31'b0, bus.rvalid}, 32'h1);
    checkOutput("rdata", bus.rdata, rdExp);
    checkOutput("rresp", {30'b0, bus.rresp}, isMapped(addr) ? 32'h0 : 32'h2);
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    checkOutput("rvalid_drop", {31'b0, bus.rvalid}, 32'h0);
  endtask

  task automatic waitIrq(input int maxCycles);
    int n;
    n = 0;
    while (irq == '0 && n < maxCycles) begin tick(); n++; end
    checkOutput("waitIrq", {31'b0, irq != '0}, 32'h1);
  endtask

  initial begin
    logic [31:0] offs [6];
    offs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    src = '0; eoi = 1'b0;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = 4'hF; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    modelReset();
    resetn = 1'b0;
    #1;
    checkOutput("rst_irq", irq, 32'h0);
    checkOutput("rst_valids", {28'b0, bus.bvalid, bus.rvalid, bus.awready, bus.arready}, 32'h0);
    repeat (3) tick();
    resetn = 1'b1;

    // Reset values of every register
    applyRead(32'h0, 0); checkOutput("rst_pending", bus.rdata, 32'h0);
    applyRead(32'h4, 0); checkOutput("rst_enable", bus.rdata, 32'h0);
    applyRead(32'h8, 0); checkOutput("rst_edge", bus.rdata, R_EDG);
    applyRead(32'hC, 0); checkOutput("rst_inservice", bus.rdata, 32'h0);

    // Two edge sources, priority and eoi sequencing with exact latency
    applyWrite(32'h4, 32'h5, 0);
    applyWrite(32'h8, 32'h5, 0);
    applyStimulus(32'h4, 1'b0);
    applyStimulus(32'h1, 1'b0);
    for (int i = 0; i < LAT - 2; i++) applyStimulus(32'h0, 1'b0);
    checkOutput("lat_irq", irq, 32'h4);
    applyRead(32'hC, 0); checkOutput("inservice_id2", bus.rdata, 32'h8000_0002);
    applyStimulus(32'h0, 1'b1);
    checkOutput("eoi_low", irq, 32'h0);
    applyStimulus(32'h0, 1'b0);
    checkOutput("next_irq", irq, 32'h1);
    applyStimulus(32'h0, 1'b1);
    applyRead(32'h0, 0); checkOutput("pending_clr", bus.rdata, 32'h0);

    // Re-edge in the eoi cycle must survive the eoi clear
    applyStimulus(32'h4, 1'b0);
    applyStimulus(32'h0, 1'b0);
    waitIrq(10);
    applyStimulus(32'h4, 1'b1);
    applyStimulus(32'h0, 1'b0);
    waitIrq(10);
    checkOutput("reassert", irq, 32'h4);
    applyStimulus(32'h0, 1'b1);

    // Level source 3 keeps re-requesting while high
    applyWrite(32'h4, 32'h8, 0);
    applyStimulus(32'h8, 1'b0);
    for (int k = 0; k < 3; k++) begin
      waitIrq(10);
      checkOutput("level_irq", irq, 32'h8);
      applyStimulus(32'h8, 1'b1);
    end
    for (int i = 0; i < 6; i++) applyStimulus(32'h0, i == 0);

    // Unmapped read, stalled responses, W1C of an edge source
    applyRead(32'h20, 2);
    checkOutput("unmapped_rdata", bus.rdata, 32'h0);
    applyWrite(32'h20, 32'hFFFF_FFFF, 0);
    applyWrite(32'h4, 32'h0, 0);
    applyStimulus(32'h1, 1'b0);
    for (int i = 0; i < LAT; i++) applyStimulus(32'h0, 1'b0);
    applyRead(32'h0, 3); checkOutput("pend0_set", bus.rdata, 32'h1);
    applyWrite(32'h0, 32'h1, 3);
    applyRead(32'h0, 0); checkOutput("pend0_w1c", bus.rdata, 32'h0);
    applyWrite(32'h10, 32'h4, 0);
    applyRead(32'h0, 0); checkOutput("swset", bus.rdata, 32'h4);

    // Randomized traffic against the model
    applyWrite(32'h8, $urandom, 0);
    applyWrite(32'h4, $urandom, 0);
    for (int it = 0; it < 500; it++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) applyWrite(offs[$urandom_range(0, 4) == 3 ? 4 : $urandom_range(0, 2)], $urandom, $urandom_range(0, 2));
      else if (r == 1) applyRead(offs[$urandom_range(0, 5)], $urandom_range(0, 2));
      else applyStimulus(N'($urandom & $urandom), $urandom_range(0, 2) == 0);
    end

    // Reset while a request is being serviced drops irq at once
    applyWrite(32'h8, 32'h2, 0);
    applyWrite(32'h4, 32'h2, 0);
    applyStimulus(32'h0, 1'b1);
    applyStimulus(32'h2, 1'b0);
    waitIrq(10);
    checkOutput("svc_irq", irq, 32'h2);
    #2 resetn = 1'b0;
    #1;
    checkOutput("async_rst_irq", irq, 32'h0);
    tick();
    resetn = 1'b1;
    applyRead(32'h4, 0); checkOutput("post_rst_enable", bus.rdata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
